// File: rtl/fire_scheduler.sv
// Single-fire scheduler: picks at most one excited cell per cycle, starting the
// scan at a round-robin pointer or at the low bits of a 16-bit LFSR.
module fire_scheduler #(
   parameter int          N    = 8,
   parameter int          CW   = 16,
   parameter int          DLK  = 4,
   parameter logic [15:0] SEED = 16'hACE1,
   localparam int         LW   = $clog2(N)
) (
   input  logic          CK,
   input  logic          RSN,
   input  logic          RUN,
   input  logic          MODE,
   input  logic [N-1:0]  EXC,
   output logic [N-1:0]  ENA,
   output logic          FIRED,
   output logic [LW-1:0] IDX,
   output logic          DEADLOCK,
   output logic [CW-1:0] STEPS
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [7:0]  DLK_LIM  = 8'(DLK);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t          state_r;
   logic [LW-1:0]   ptr_r;
   logic [15:0]     lfsr_r;
   logic [CW-1:0]   steps_r;
   logic [7:0]      idle_r;
   logic            deadlock_r;

   logic [LW-1:0]   start_s;
   logic [N-1:0]    rot_s;
   logic [LW-1:0]   off_s;
   logic            hit_s;
   logic [LW-1:0]   sel_s;
   logic            lfsr_fb_s;
   logic [7:0]      idle_base_s;
   logic [7:0]      idle_nxt_s;

   // Rotate EXC so the start index lands on bit 0, then take the lowest set bit.
   always_comb begin
      start_s = MODE ? lfsr_r[LW-1:0] : ptr_r;
      rot_s   = N'({EXC, EXC} >> start_s);
      off_s   = '0;
      hit_s   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            off_s = LW'(k);
            hit_s = 1'b1;
         end else begin
            off_s = off_s;
         end
      end
      sel_s = start_s + off_s;
      if (RSN && RUN && hit_s) begin
         FIRED = 1'b1;
         IDX   = sel_s;
         ENA   = {{(N-1){1'b0}}, 1'b1} << sel_s;
      end else begin
         FIRED = 1'b0;
         IDX   = '0;
         ENA   = '0;
      end
   end

   // Next idle count; restarts from zero on the edge that enters ACTIVE.
   always_comb begin
      lfsr_fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
      idle_base_s = (state_r == IDLE) ? 8'd0 : idle_r;
      if (idle_base_s < DLK_LIM) begin
         idle_nxt_s = idle_base_s + 8'd1;
      end else begin
         idle_nxt_s = idle_base_s;
      end
   end

   // Controller state, pointer, LFSR, step counter and deadlock detection.
   always_ff @(posedge CK or negedge RSN) begin
      if (!RSN) begin
         state_r    <= IDLE;
         ptr_r      <= '0;
         lfsr_r     <= SEED_EFF;
         steps_r    <= '0;
         idle_r     <= 8'd0;
         deadlock_r <= 1'b0;
      end else begin
         state_r <= RUN ? ACTIVE : IDLE;
         if (FIRED) begin
            ptr_r <= IDX + LW'(1);
         end else begin
            ptr_r <= ptr_r;
         end
         if (RUN) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
         end else begin
            lfsr_r <= lfsr_r;
         end
         if (FIRED && (steps_r != {CW{1'b1}})) begin
            steps_r <= steps_r + CW'(1);
         end else begin
            steps_r <= steps_r;
         end
         if (RUN && (EXC == '0)) begin
            idle_r     <= idle_nxt_s;
            deadlock_r <= deadlock_r | (idle_nxt_s == DLK_LIM);
         end else begin
            idle_r     <= 8'd0;
            deadlock_r <= 1'b0;
         end
      end
   end

   assign DEADLOCK = deadlock_r;
   assign STEPS    = steps_r;

endmodule

// File: tb/tb_fire_scheduler.sv
// Scoreboard bench for fire_scheduler: a reference model predicts ENA/IDX/FIRED
// each cycle plus STEPS/DEADLOCK after each edge; a CW=4 copy covers saturation.
module tb_fire_scheduler;

   logic       CK = 1'b0;
   logic       RSN;
   logic       RUN;
   logic       MODE;
   logic [7:0] EXC;
   logic [7:0] ENA, ENA4;
   logic       FIRED, FIRED4;
   logic [2:0] IDX, IDX4;
   logic       DEADLOCK, DL4;
   logic [15:0] STEPS;
   logic [3:0]  STEPS4;

   fire_scheduler dut (
      .CK(CK), .RSN(RSN), .RUN(RUN), .MODE(MODE), .EXC(EXC),
      .ENA(ENA), .FIRED(FIRED), .IDX(IDX), .DEADLOCK(DEADLOCK), .STEPS(STEPS)
   );

   fire_scheduler #(.CW(4)) dut4 (
      .CK(CK), .RSN(RSN), .RUN(RUN), .MODE(MODE), .EXC(EXC),
      .ENA(ENA4), .FIRED(FIRED4), .IDX(IDX4), .DEADLOCK(DL4), .STEPS(STEPS4)
   );

   always #5 CK = ~CK;

   typedef struct {
      logic [7:0] ena;
      logic [2:0] idx;
      logic       fired;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   logic [2:0]  m_ptr;
   logic [15:0] m_lfsr;
   int          m_steps, m_steps4, m_idle;
   logic        m_dl;

   function automatic exp_t predict(input logic run, input logic mode, input logic [7:0] exc);
      exp_t e;
      logic [2:0] s, i;
      e.ena = 8'h00; e.idx = 3'd0; e.fired = 1'b0;
      s = mode ? m_lfsr[2:0] : m_ptr;
      if (run) begin
         for (int k = 0; k < 8; k++) begin
            i = 3'(s + 3'(k));
            if (!e.fired && exc[i]) begin
               e.fired = 1'b1; e.idx = i; e.ena = 8'h01 << i;
            end
         end
      end
      return e;
   endfunction

   task automatic model_edge(input logic run, input logic [7:0] exc, input exp_t e);
      if (e.fired) begin
         m_ptr = e.idx + 3'd1;
         if (m_steps < 65535) m_steps++;
         if (m_steps4 < 15) m_steps4++;
      end
      if (run) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (run && exc == 8'h00) begin
         if (m_idle < 4) m_idle++;
         if (m_idle == 4) m_dl = 1'b1;
      end else begin
         m_idle = 0; m_dl = 1'b0;
      end
   endtask

   // One clock: drive at the falling edge, check combinational outputs, then registered ones.
   task automatic cycle(input logic run, input logic mode, input logic [7:0] exc,
                        output logic [2:0] idx_o, output logic [7:0] ena_o);
      exp_t e;
      RUN = run; MODE = mode; EXC = exc;
      sb.push_back(predict(run, mode, exc));
      #1;
      e = sb.pop_front();
      checks += 4;
      if (ENA !== e.ena) begin errors++; $display("FAIL ena: got %h want %h", ENA, e.ena); end
      if (IDX !== e.idx) begin errors++; $display("FAIL idx: got %0d want %0d", IDX, e.idx); end
      if (FIRED !== e.fired) begin errors++; $display("FAIL fired: got %b want %b", FIRED, e.fired); end
      if (ENA4 !== e.ena) begin errors++; $display("FAIL ena_cw4: got %h want %h", ENA4, e.ena); end
      idx_o = IDX; ena_o = ENA;
      @(posedge CK);
      #1;
      model_edge(run, exc, e);
      checks += 3;
      if (STEPS !== 16'(m_steps)) begin errors++; $display("FAIL steps: got %0d want %0d", STEPS, m_steps); end
      if (STEPS4 !== 4'(m_steps4)) begin errors++; $display("FAIL steps_cw4: got %0d want %0d", STEPS4, m_steps4); end
      if (DEADLOCK !== m_dl) begin errors++; $display("FAIL deadlock: got %b want %b", DEADLOCK, m_dl); end
      @(negedge CK);
   endtask

   task automatic do_reset();
      RSN = 1'b0; RUN = 1'b1; MODE = 1'b0; EXC = 8'hFF;
      #1;
      checks += 5;
      if (ENA !== 8'h00) begin errors++; $display("FAIL rst_ena: got %h want 00", ENA); end
      if (FIRED !== 1'b0) begin errors++; $display("FAIL rst_fired: got %b want 0", FIRED); end
      if (IDX !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", IDX); end
      if (STEPS !== 16'd0) begin errors++; $display("FAIL rst_steps: got %0d want 0", STEPS); end
      if (DEADLOCK !== 1'b0) begin errors++; $display("FAIL rst_deadlock: got %b want 0", DEADLOCK); end
      m_ptr = 3'd0; m_lfsr = 16'hACE1; m_steps = 0; m_steps4 = 0; m_idle = 0; m_dl = 1'b0;
      @(posedge CK);
      @(negedge CK);
      RUN = 1'b0;
      RSN = 1'b1;
      #1;
      checks++;
      if (STEPS !== 16'd0) begin errors++; $display("FAIL rel_steps: got %0d want 0", STEPS); end
      @(negedge CK);
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [2:0] ix; logic [7:0] en;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         cycle(1'b1, 1'b0, 8'hFF, ix, en);
         checks++;
         if (ix !== 3'(c % 8)) begin errors++; $display("FAIL rr_seq: got %0d want %0d", ix, c % 8); end
      end
      checks++;
      if (STEPS !== 16'd10) begin errors++; $display("FAIL rr_steps: got %0d want 10", STEPS); end
   endtask

   task automatic test_wrap();
      logic [2:0] ix; logic [7:0] en;
      do_reset();
      for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 8'hFF, ix, en);
      cycle(1'b1, 1'b0, 8'h05, ix, en);
      checks += 2;
      if (en !== 8'h01) begin errors++; $display("FAIL wrap_ena: got %h want 01", en); end
      if (ix !== 3'd0) begin errors++; $display("FAIL wrap_idx: got %0d want 0", ix); end
      cycle(1'b1, 1'b0, 8'h05, ix, en);
      checks++;
      if (en !== 8'h04) begin errors++; $display("FAIL wrap_next: got %h want 04", en); end
   endtask

   task automatic test_deadlock();
      logic [2:0] ix; logic [7:0] en;
      do_reset();
      for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 8'h00, ix, en);
      checks++;
      if (DEADLOCK !== 1'b0) begin errors++; $display("FAIL dl_early: got %b want 0", DEADLOCK); end
      cycle(1'b1, 1'b0, 8'h00, ix, en);
      checks++;
      if (DEADLOCK !== 1'b1) begin errors++; $display("FAIL dl_set: got %b want 1", DEADLOCK); end
      cycle(1'b1, 1'b0, 8'h00, ix, en);
      checks++;
      if (DEADLOCK !== 1'b1) begin errors++; $display("FAIL dl_hold: got %b want 1", DEADLOCK); end
      cycle(1'b1, 1'b0, 8'h10, ix, en);
      checks += 2;
      if (en !== 8'h10) begin errors++; $display("FAIL dl_exc_ena: got %h want 10", en); end
      if (DEADLOCK !== 1'b0) begin errors++; $display("FAIL dl_clear: got %b want 0", DEADLOCK); end
   endtask

   task automatic test_saturation();
      logic [2:0] ix; logic [7:0] en;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         cycle(1'b1, 1'b0, 8'hFF, ix, en);
         checks++;
         if (!$onehot(ENA4)) begin errors++; $display("FAIL sat_onehot: got %h want one-hot", ENA4); end
      end
      checks++;
      if (STEPS4 !== 4'd15) begin errors++; $display("FAIL sat_steps: got %0d want 15", STEPS4); end
   endtask

   task automatic test_lfsr();
      logic [2:0] ix; logic [7:0] en;
      do_reset();
      cycle(1'b1, 1'b1, 8'hFF, ix, en);
      checks++;
      if (ix !== 3'd1) begin errors++; $display("FAIL lfsr_first: got %0d want 1", ix); end
      for (int c = 0; c < 15; c++) begin
         cycle(1'b1, 1'b1, 8'hFF, ix, en);
         checks++;
         if (!$onehot(en)) begin errors++; $display("FAIL lfsr_onehot: got %h want one-hot", en); end
      end
   endtask

   task automatic test_mid_reset();
      logic [2:0] ix; logic [7:0] en;
      do_reset();
      for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 8'hFF, ix, en);
      cycle(1'b1, 1'b0, 8'h04, ix, en);
      checks += 2;
      if (ix !== 3'd2) begin errors++; $display("FAIL mr_idx: got %0d want 2", ix); end
      if (STEPS !== 16'd5) begin errors++; $display("FAIL mr_steps: got %0d want 5", STEPS); end
      do_reset();
      cycle(1'b1, 1'b0, 8'hFF, ix, en);
      checks++;
      if (ix !== 3'd0) begin errors++; $display("FAIL mr_first: got %0d want 0", ix); end
   endtask

   task automatic test_random();
      logic [2:0] ix; logic [7:0] en;
      logic [7:0] x;
      do_reset();
      for (int c = 0; c < 80; c++) begin
         x = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) x = 8'h00;
         cycle(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), x, ix, en);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wrap();
      test_deadlock();
      test_saturation();
      test_lfsr();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fire_scheduler.md
FIRE_SCHEDULER -- requirements
Module: fire_scheduler

Interface
REQ-001 Parameter N, default 8: number of scheduled cells; SHALL be a power of two, 2..32.
REQ-002 Parameter CW, default 16: width of the fire-step counter.
REQ-003 Parameter DLK, default 4: consecutive idle cycles before a deadlock is flagged, range 1..255.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; a SEED of 0 SHALL be replaced by 16'h0001.
REQ-005 CK  input  1  clock; all state updates on the rising edge.
REQ-006 RSN  input  1  reset; asynchronous, active-low.
REQ-007 RUN  input  1  scheduling enable; 0 means no cell fires.
REQ-008 MODE  input  1  selection policy; 0 = round-robin, 1 = pseudo-random (LFSR).
REQ-009 EXC  input  N  per-cell excitation flags; bit i = 1 means cell i can change.
REQ-010 ENA  output  N  per-cell enable; at most one bit set; drives each cell's ENA pin.
REQ-011 FIRED  output  1  OR of ENA.
REQ-012 IDX  output  log2(N)  index of the set ENA bit; 0 when FIRED = 0.
REQ-013 DEADLOCK  output  1  sticky flag: no excited cell for DLK cycles while RUN = 1.
REQ-014 STEPS  output  CW  count of fire events since reset.

Function
REQ-015 ENA SHALL be combinational from EXC, RUN, MODE and registered state, so a cell fires on the same CK edge at which its ENA is sampled.
REQ-016 ENA SHALL be all zero when RSN = 0, when RUN = 0, or when EXC = 0.
REQ-017 Start index S SHALL be PTR when MODE = 0, and LFSR[log2(N)-1:0] when MODE = 1.
REQ-018 ENA SHALL select the first i with EXC[i] = 1, scanning S, S+1, ... modulo N (wrap N-1 to 0).
REQ-019 PTR SHALL load (IDX+1) mod N on every edge where FIRED = 1, in either mode, and SHALL hold otherwise.
REQ-020 LFSR SHALL be 16-bit Fibonacci, shifting left every edge while RUN = 1.
REQ-021 The LFSR input bit 0 SHALL be LFSR[15]^LFSR[13]^LFSR[12]^LFSR[10].
REQ-022 The LFSR SHALL hold while RUN = 0.
REQ-023 STEPS SHALL increment by 1 on each edge with FIRED = 1 and SHALL saturate at 2^CW-1, with no wrap.
REQ-024 Idle counter: +1 on each edge with RUN = 1 and EXC = 0; cleared on any edge with EXC != 0 or RUN = 0.
REQ-025 DEADLOCK SHALL set on the edge at which the idle counter reaches DLK.
REQ-026 DEADLOCK SHALL stay set while EXC = 0, and SHALL clear on the first edge with RUN = 0 or EXC != 0.
REQ-027 Two-state controller: IDLE (RUN = 0) and ACTIVE (RUN = 1); the state is RUN registered, used only to clear the idle counter on the ACTIVE entry edge.
REQ-028 A MODE change mid-run SHALL take effect in the same cycle; PTR and LFSR SHALL retain their values across the change.
REQ-029 An EXC change within a cycle SHALL be reflected in ENA within that cycle; there SHALL be no registered stale enable.

Reset
REQ-030 RSN = 0 SHALL immediately force PTR = 0, LFSR = SEED (or 1), STEPS = 0, idle counter = 0, DEADLOCK = 0 and state = IDLE, with ENA = 0, FIRED = 0 and IDX = 0.
REQ-031 Reset asserted mid-operation SHALL abort any pending selection; the first fire after RSN rises SHALL use S = 0 (MODE = 0) or S = SEED bits (MODE = 1).
REQ-032 Release of RSN SHALL take effect synchronously to CK, with no fire on the release edge unless RUN = 1 and EXC != 0.

Verification
REQ-033 N=8, MODE=0, RUN=1, EXC=8'hFF held for 10 cycles -> IDX sequence 0,1,2,...,7,0,1; STEPS=10.
REQ-034 MODE=0, PTR=6, EXC=8'b0000_0101 -> ENA=8'h01, IDX=0 (wrap); next edge PTR=1; next cycle ENA=8'h04.
REQ-035 RUN=1, EXC=0, DLK=4 -> DEADLOCK rises on the 4th edge; EXC=8'h10 applied -> ENA=8'h10 same cycle, DEADLOCK=0 after the next edge.
REQ-036 CW=4, EXC=8'hFF, 20 cycles -> STEPS=15 and held; ENA still one-hot every cycle.
REQ-037 MODE=1, SEED=16'hACE1, EXC=8'hFF -> first IDX=1 (SEED[2:0]), then the LFSR-determined sequence; ENA is one-hot every cycle, checked against a reference LFSR model.
REQ-038 RSN pulsed low mid-run with STEPS=5 and PTR=3 -> ENA=0 during reset; after release STEPS=0, first IDX=0 with EXC=8'hFF.
